pipe_stage_buf: RTL

//  Parametrised pipeline stage register for the MIPS core (IF/ID, ID/EX, ...).

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_slot.sv | 49 ++++
 rtl/pipe_stage_buf.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared constants and state encoding for the pipeline stage buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam logic [31:0] c_nop_instr_default = 32'h0000_0000;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] count_of(input state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module : pipe_slot
// Brief  : One pipeline entry: valid bit plus instruction/PC payload register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_slot #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // Payload is left untouched on clear; consumers gate it with valid.
    always_ff @(posedge i_clk) begin
        if (i_load && !i_clr) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// Module : pipe_stage_buf
// Brief  : Pipeline stage register with valid/ready handshake, flush and an
//          optional 2-entry skid buffer giving a registered o_ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(c_nop_instr_default),
    parameter bit                 SKID_EN   = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic [1:0]         o_count
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_ready;
    logic               w_accept;
    logic               w_drain;
    logic               w_main_load;
    logic               w_main_from_skid;
    logic               w_main_clr;
    logic               w_skid_load;
    logic               w_skid_clr;
    logic               w_main_valid;
    logic [INSTR_W-1:0] w_main_instr;
    logic [PC_W-1:0]    w_main_pc;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pc;
    logic [INSTR_W-1:0] w_main_d_instr;
    logic [PC_W-1:0]    w_main_d_pc;

    assign w_accept = i_valid & w_ready;
    assign w_drain  = w_main_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clr       = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    // Without a skid, accept in ONE implies drain, so FULL is unreachable.
                    if (w_accept && w_drain) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_drain) begin
                        w_main_clr  = 1'b1;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d_instr = w_main_from_skid ? w_skid_instr : i_instr;
    assign w_main_d_pc    = w_main_from_skid ? w_skid_pc    : i_pc;

    pipe_slot #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_main (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_main_clr),
        .i_load  (w_main_load),
        .i_instr (w_main_d_instr),
        .i_pc    (w_main_d_pc),
        .o_valid (w_main_valid),
        .o_instr (w_main_instr),
        .o_pc    (w_main_pc)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic r_ready;
            logic w_unused_skid_valid;

            pipe_slot #(
                .INSTR_W (INSTR_W),
                .PC_W    (PC_W)
            ) u_skid (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_clr   (w_skid_clr),
                .i_load  (w_skid_load),
                .i_instr (i_instr),
                .i_pc    (i_pc),
                .o_valid (w_unused_skid_valid),
                .o_instr (w_skid_instr),
                .o_pc    (w_skid_pc)
            );

            // Ready is computed from the next state so it is a pure flop output.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ready <= 1'b1;
                end else begin
                    r_ready <= (w_state_nxt != ST_FULL);
                end
            end

            assign w_ready = r_ready;
        end else begin : g_noskid
            logic w_unused_skid;

            assign w_skid_instr  = '0;
            assign w_skid_pc     = '0;
            assign w_unused_skid = w_skid_load ^ w_skid_clr;
            assign w_ready       = ~w_main_valid | i_ready;
        end
    endgenerate

    assign o_ready = w_ready;
    assign o_valid = w_main_valid;
    assign o_instr = w_main_valid ? w_main_instr : NOP_INSTR;
    assign o_pc    = w_main_valid ? w_main_pc : '0;
    assign o_count = count_of(r_state);

endmodule

`default_nettype wire
